// File: rtl/lab_e_pkg.sv
// Shared definitions for the Lab E serial datapath blocks.
// Contents: default operand width (shared with the ripple adder), the FSM
// state type and encodings, and a helper that sizes the bit counter.
package lab_e_pkg;

  // Operand width used by both the Lab E adder and this subtractor.
  localparam int LAB_E_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit-counter width: $clog2(w), but never narrower than one bit,
  // so that WIDTH=1 still has a real counter register.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/lab_e_serial_sub_if.sv
// Handshake/data bundle for lab_e_serial_sub.
// Signals: Start, A, B, Bi (requester -> subtractor);
//          Diff, Bo, Busy, Done (subtractor -> requester).
// master: the side issuing requests; slave: the subtractor itself.
interface lab_e_serial_sub_if #(
  parameter int WIDTH = lab_e_pkg::LAB_E_WIDTH
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bi;
  logic [WIDTH-1:0] Diff;
  logic             Bo;
  logic             Busy;
  logic             Done;

  modport master (output Start, A, B, Bi, input Diff, Bo, Busy, Done);
  modport slave  (input Start, A, B, Bi, output Diff, Bo, Busy, Done);
endinterface

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: computes a - b - bin.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in)
//        -> d (difference bit), bout (borrow out). Purely combinational.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow equations of the full subtractor.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
  end

endmodule

// File: rtl/lab_e_serial_sub.sv
// Bit-serial subtractor: Diff = (A - B - Bi) mod 2^WIDTH, LSB first, one bit
// per clock through a single full_sub_cell and a borrow flop.
// Ports: clk, rst_n (async active-low), bus (slave side of
//        lab_e_serial_sub_if: Start/A/B/Bi in, Diff/Bo/Busy/Done out).
module lab_e_serial_sub
  import lab_e_pkg::*;
#(
  parameter int WIDTH = LAB_E_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  lab_e_serial_sub_if.slave bus
);

  localparam int          CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [WIDTH-1:0] diff_r;
  logic             br_r;
  logic             bo_r;
  logic             cell_d_s;
  logic             cell_bo_s;
  logic             last_s;
  logic             busy_s;
  logic             done_s;

  full_sub_cell u_cell (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (br_r),
    .d    (cell_d_s),
    .bout (cell_bo_s)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // Result register after this step: shift right, new bit enters at the MSB.
  // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
  always_comb begin
    res_nxt_s            = res_r >> 1'b1;
    res_nxt_s[WIDTH-1]   = cell_d_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) state_nxt_s = ST_SHIFT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_SHIFT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state register.
  always_comb begin
    busy_s = (state_r != ST_IDLE);
    done_s = (state_r == ST_DONE);
  end

  // Datapath: operand capture, serial shifting, borrow flop and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      a_sh_r <= '0;
      b_sh_r <= '0;
      res_r  <= '0;
      diff_r <= '0;
      br_r   <= 1'b0;
      bo_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.Start) begin
            a_sh_r <= bus.A;
            b_sh_r <= bus.B;
            br_r   <= bus.Bi;
            cnt_r  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh_r <= a_sh_r >> 1'b1;
          b_sh_r <= b_sh_r >> 1'b1;
          res_r  <= res_nxt_s;
          br_r   <= cell_bo_s;
          cnt_r  <= cnt_r + CW'(1);
          // Publish on the edge that enters DONE so Diff/Bo change together
          // with the rising Done pulse and stay frozen throughout SHIFT.
          if (last_s) begin
            diff_r <= res_nxt_s;
            bo_r   <= cell_bo_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Diff = diff_r;
  assign bus.Bo   = bo_r;
  assign bus.Busy = busy_s;
  assign bus.Done = done_s;

endmodule

// File: tb/tb_lab_e_serial_sub.sv
// Self-checking bench for lab_e_serial_sub: table-driven subtract vectors,
// adder round-trip vectors, busy/reset corner sequences, and max-rate
// random runs on WIDTH=4, 1 and 8 instances.
module tb_lab_e_serial_sub;
  import lab_e_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lab_e_serial_sub_if #(.WIDTH(4)) bus4 ();
  lab_e_serial_sub_if #(.WIDTH(1)) bus1 ();
  lab_e_serial_sub_if #(.WIDTH(8)) bus8 ();

  lab_e_serial_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  lab_e_serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  lab_e_serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] diff;
    logic       bo;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
  } add_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic drive(input int sel, input logic start, input logic [7:0] a,
                       input logic [7:0] b, input logic bi);
    case (sel)
      0: begin bus4.Start = start; bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.Bi = bi; end
      1: begin bus1.Start = start; bus1.A = a[0:0]; bus1.B = b[0:0]; bus1.Bi = bi; end
      default: begin bus8.Start = start; bus8.A = a; bus8.B = b; bus8.Bi = bi; end
    endcase
  endtask

  // Packed view: [10]=Done [9]=Busy [8]=Bo [7:0]=Diff
  function automatic logic [10:0] sample(input int sel);
    case (sel)
      0:       return {bus4.Done, bus4.Busy, bus4.Bo, 4'd0, bus4.Diff};
      1:       return {bus1.Done, bus1.Busy, bus1.Bo, 7'd0, bus1.Diff};
      default: return {bus8.Done, bus8.Busy, bus8.Bo, bus8.Diff};
    endcase
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns just after a
  // negedge with the DUT back in IDLE, so consecutive calls run at max rate.
  task automatic run_op(input int sel, input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic bi,
                        input logic [7:0] exp_diff, input logic exp_bo);
    int n;
    logic seen;
    logic [10:0] s;
    drive(sel, 1'b1, a, b, bi);
    @(negedge clk);
    drive(sel, 1'b0, ~a, ~b, ~bi);
    s = sample(sel);
    check({tag, " busy_after_accept"}, int'(s[9]), 1);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      s = sample(sel);
      if (s[10]) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, " latency"}, n, width_of(sel) + 1);
    check({tag, " diff"}, int'(s[7:0]), int'(exp_diff));
    check({tag, " bo"}, int'(s[8]), int'(exp_bo));
    @(negedge clk);
    s = sample(sel);
    check({tag, " done_pulse_ends"}, int'(s[10]), 0);
    check({tag, " busy_falls"}, int'(s[9]), 0);
  endtask

  task automatic run_random(input int sel, input int count);
    int unsigned w, m, ea, eb, ebi, ed, ebo;
    w = width_of(sel);
    m = (32'd1 << w) - 32'd1;
    for (int i = 0; i < count; i++) begin
      ea  = $urandom & m;
      eb  = $urandom & m;
      ebi = $urandom_range(1, 0);
      ed  = (ea - eb - ebi) & m;
      ebo = (ea < eb + ebi) ? 32'd1 : 32'd0;
      run_op(sel, $sformatf("rnd_w%0d_%0d", w, i), ea[7:0], eb[7:0], ebi[0],
             ed[7:0], ebo[0]);
    end
  endtask

  vec_t vecs[6];
  add_t adds[10];

  initial begin
    logic [10:0] s;
    logic [4:0]  sum5;
    logic        done_seen;
    int          n;

    vecs[0] = '{a: 4'd9,  b: 4'd6, bi: 1'b0, diff: 4'd3,  bo: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd6, bi: 1'b0, diff: 4'd13, bo: 1'b1};
    vecs[2] = '{a: 4'd8,  b: 4'd8, bi: 1'b1, diff: 4'd15, bo: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd0, bi: 1'b1, diff: 4'd15, bo: 1'b1};
    vecs[4] = '{a: 4'd15, b: 4'd0, bi: 1'b0, diff: 4'd15, bo: 1'b0};
    vecs[5] = '{a: 4'd4,  b: 4'd1, bi: 1'b1, diff: 4'd2,  bo: 1'b0};

    adds[0] = '{a: 4'd11, b: 4'd7,  ci: 1'b0};
    adds[1] = '{a: 4'd13, b: 4'd14, ci: 1'b1};
    adds[2] = '{a: 4'd0,  b: 4'd0,  ci: 1'b0};
    adds[3] = '{a: 4'd15, b: 4'd15, ci: 1'b1};
    adds[4] = '{a: 4'd5,  b: 4'd3,  ci: 1'b0};
    adds[5] = '{a: 4'd1,  b: 4'd1,  ci: 1'b1};
    adds[6] = '{a: 4'd7,  b: 4'd8,  ci: 1'b0};
    adds[7] = '{a: 4'd9,  b: 4'd9,  ci: 1'b0};
    adds[8] = '{a: 4'd15, b: 4'd1,  ci: 1'b0};
    adds[9] = '{a: 4'd6,  b: 4'd10, ci: 1'b1};

    // Reset state
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      s = sample(k);
      check($sformatf("reset_outputs_w%0d", width_of(k)), int'(s), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven subtract vectors
    for (int i = 0; i < 6; i++)
      run_op(0, $sformatf("vec%0d", i), {4'd0, vecs[i].a}, {4'd0, vecs[i].b},
             vecs[i].bi, {4'd0, vecs[i].diff}, vecs[i].bo);

    // Adder round-trip: subtracting B and carry from Sum recovers A, Bo=Co
    for (int i = 0; i < 10; i++) begin
      sum5 = {1'b0, adds[i].a} + {1'b0, adds[i].b} + {4'd0, adds[i].ci};
      run_op(0, $sformatf("roundtrip%0d", i), {4'd0, sum5[3:0]}, {4'd0, adds[i].b},
             adds[i].ci, {4'd0, adds[i].a}, sum5[4]);
    end

    // Start ignored while busy (mid-SHIFT and in DONE)
    drive(0, 1'b1, 8'd9, 8'd6, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 8'd1, 8'd2, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    n = 3;
    s = sample(0);
    while (!s[10] && n < 40) begin
      @(negedge clk);
      n++;
      s = sample(0);
    end
    check("busy_ign latency", n, 5);
    check("busy_ign diff", int'(s[7:0]), 3);
    check("busy_ign bo", int'(s[8]), 0);
    drive(0, 1'b1, 8'd15, 8'd1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    s = sample(0);
    check("busy_ign busy_after_done", int'(s[9]), 0);
    @(negedge clk);
    s = sample(0);
    check("busy_ign start_in_done_dropped", int'(s[9]), 0);
    check("busy_ign diff_held", int'(s[7:0]), 3);
    run_op(0, "busy_ign next", 8'd12, 8'd5, 1'b0, 8'd7, 1'b0);

    // Reset mid-operation: leave a nonzero result first
    run_op(0, "pre_rst", 8'd3, 8'd6, 1'b0, 8'd13, 1'b1);
    drive(0, 1'b1, 8'd9, 8'd6, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    s = sample(0);
    check("midrst diff", int'(s[7:0]), 0);
    check("midrst bo", int'(s[8]), 0);
    check("midrst busy", int'(s[9]), 0);
    check("midrst done", int'(s[10]), 0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | bus4.Done;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      done_seen = done_seen | bus4.Done;
    end
    check("midrst no_done", int'(done_seen), 0);
    run_op(0, "after_rst", 8'd4, 8'd1, 1'b1, 8'd2, 1'b0);

    // Max-rate random runs on each width
    run_random(0, 200);
    run_random(1, 200);
    run_random(2, 200);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
